// File: rtl/raw10_pkg.sv
// raw10_pkg
// Shared sizing constants and types for the RAW10 encoder slice.
//   PIX_W         - bits per pixel
//   PIX_PER_GRP   - pixels per input group
//   BYTES_PER_GRP - packed bytes produced per group
//   BUF_BYTES     - capacity of the encoder byte buffer
package raw10_pkg;

  localparam int PIX_W         = 10;
  localparam int PIX_PER_GRP   = 4;
  localparam int BYTES_PER_GRP = 5;
  localparam int BUF_BYTES     = 8;

  // Each pixel occupies a 16-bit lane of the input group.
  localparam int LANE_W = 16;
  localparam int GRP_W  = LANE_W * PIX_PER_GRP;
  localparam int PACK_W = 8 * BYTES_PER_GRP;
  localparam int BUF_W  = 8 * BUF_BYTES;

  // Byte occupancy of the buffer, 0..8.
  typedef logic [3:0] count_t;

  localparam count_t CNT_ZERO    = 4'd0;
  localparam count_t CNT_ONE     = 4'd1;
  localparam count_t CNT_TWO     = 4'd2;
  localparam count_t CNT_GRP     = 4'd5;
  // Highest occupancy at which a whole group still fits after one emission.
  localparam count_t CNT_RDY_MAX = 4'd5;

endpackage

// File: rtl/raw10_pack.sv
// raw10_pack
// Combinational RAW10 packer: four 10-bit pixels -> five bytes.
//   grp   [63:0] - pixel k in lane k bits [9:0]; lane bits [15:10] ignored
//   bytes [39:0] - byte k (k=0..3) = pixel k[9:2];
//                  byte 4 = {p3[1:0], p2[1:0], p1[1:0], p0[1:0]}
module raw10_pack
  import raw10_pkg::*;
(
  input  logic [GRP_W-1:0]  grp,
  output logic [PACK_W-1:0] bytes
);

  // The upper six bits of every lane carry no pixel data.
  logic unused_upper_s;
  assign unused_upper_s = ^{grp[63:58], grp[47:42], grp[31:26], grp[15:10]};

  // Split each pixel into its 8 MSBs (own byte) and 2 LSBs (shared fifth byte).
  always_comb begin
    bytes = {PACK_W{1'b0}};
    for (int k = 0; k < PIX_PER_GRP; k++) begin
      bytes[8*k +: 8] = grp[LANE_W*k + (PIX_W-8) +: 8];
      bytes[8*PIX_PER_GRP + (PIX_W-8)*k +: (PIX_W-8)] = grp[LANE_W*k +: (PIX_W-8)];
    end
  end

endmodule

// File: rtl/raw10_encoder.sv
// raw10_encoder
// Packs groups of four RAW10 pixels into a byte stream and emits it two bytes
// per cycle. An 8-byte FIFO buffer decouples 5-byte groups from 2-byte words;
// an odd-length line is closed with a zero-padded final word.
//   clk        - clock, all state on the rising edge
//   reset      - asynchronous active-low reset
//   pix_data   - four pixels, pixel k in [16k+9:16k]
//   pix_valid  - pix_data/pix_last valid
//   pix_last   - group is the final one of the line
//   pix_ready  - group accepted when pix_valid & pix_ready
//   dout       - first byte [7:0], second byte [15:8]; zero when idle
//   dout_valid - dout carries data
//   dout_last  - dout is the final word of the line
module raw10_encoder
  import raw10_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [GRP_W-1:0] pix_data,
  input  logic             pix_valid,
  input  logic             pix_last,
  output logic             pix_ready,
  output logic [15:0]      dout,
  output logic             dout_valid,
  output logic             dout_last
);

  logic [PACK_W-1:0] pack_s;
  logic [BUF_W-1:0]  buf_r;
  logic [BUF_W-1:0]  buf_nxt_s;
  count_t            count_r;
  count_t            count_nxt_s;
  count_t            drop_s;
  count_t            base_s;
  logic              last_pending_r;
  logic              last_pending_nxt_s;
  logic              pix_ready_r;
  logic              pix_ready_nxt_s;
  logic [15:0]       dout_r;
  logic [15:0]       dout_nxt_s;
  logic              dout_valid_r;
  logic              dout_valid_nxt_s;
  logic              dout_last_r;
  logic              dout_last_nxt_s;
  logic              accept_s;

  raw10_pack u_pack (
    .grp   (pix_data),
    .bytes (pack_s)
  );

  assign accept_s = pix_valid & pix_ready_r;

  // Choose this cycle's emission from the oldest buffered bytes (byte 0 = oldest).
  always_comb begin
    dout_nxt_s       = 16'h0000;
    dout_valid_nxt_s = 1'b0;
    dout_last_nxt_s  = 1'b0;
    drop_s           = CNT_ZERO;
    if (count_r >= CNT_TWO) begin
      dout_nxt_s       = buf_r[15:0];
      dout_valid_nxt_s = 1'b1;
      dout_last_nxt_s  = last_pending_r & (count_r == CNT_TWO);
      drop_s           = CNT_TWO;
    end else if ((count_r == CNT_ONE) && last_pending_r) begin
      // Lone trailing byte of an odd-length line goes out padded.
      dout_nxt_s       = {8'h00, buf_r[7:0]};
      dout_valid_nxt_s = 1'b1;
      dout_last_nxt_s  = 1'b1;
      drop_s           = CNT_ONE;
    end else begin
      // A single byte mid-line waits for the next group to pair with.
      drop_s = CNT_ZERO;
    end
  end

  // Occupancy left after emission; an accepted group lands right behind it.
  assign base_s = count_r - drop_s;

  // Next buffer/count/last state: shift out emitted bytes, then append the group.
  always_comb begin
    buf_nxt_s          = buf_r >> {drop_s, 3'b000};
    count_nxt_s        = base_s;
    last_pending_nxt_s = last_pending_r;
    if (accept_s) begin
      // Bytes at or above the count are always zero, so OR-ing places the group.
      buf_nxt_s          = buf_nxt_s | ({{(BUF_W-PACK_W){1'b0}}, pack_s} << {base_s, 3'b000});
      count_nxt_s        = base_s + CNT_GRP;
      last_pending_nxt_s = pix_last;
    end else if (dout_last_nxt_s) begin
      last_pending_nxt_s = 1'b0;
    end else begin
      last_pending_nxt_s = last_pending_r;
    end
    // Ready is registered so it reads 0 during reset yet tracks the stored state.
    pix_ready_nxt_s = (count_nxt_s <= CNT_RDY_MAX) & ~last_pending_nxt_s;
  end

  // State and output registers; reset discards any partially buffered line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_r          <= {BUF_W{1'b0}};
      count_r        <= CNT_ZERO;
      last_pending_r <= 1'b0;
      pix_ready_r    <= 1'b0;
      dout_r         <= 16'h0000;
      dout_valid_r   <= 1'b0;
      dout_last_r    <= 1'b0;
    end else begin
      buf_r          <= buf_nxt_s;
      count_r        <= count_nxt_s;
      last_pending_r <= last_pending_nxt_s;
      pix_ready_r    <= pix_ready_nxt_s;
      dout_r         <= dout_nxt_s;
      dout_valid_r   <= dout_valid_nxt_s;
      dout_last_r    <= dout_last_nxt_s;
    end
  end

  assign pix_ready  = pix_ready_r;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign dout_last  = dout_last_r;

endmodule

// File: doc/raw10_encoder.md
RAW10_ENCODER -- requirements
Module: raw10_encoder

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
REQ-003 pix_data  input  64  four pixels; pixel k in [16k+9:16k], bits [16k+15:16k+10] ignored.
REQ-004 pix_valid  input  1  pix_data/pix_last valid this cycle.
REQ-005 pix_last  input  1  this group is the final group of the line.
REQ-006 pix_ready  output  1  encoder accepts a group this cycle; transfer = pix_valid & pix_ready.
REQ-007 dout  output  16  two packed bytes; first byte in [7:0], second in [15:8].
REQ-008 dout_valid  output  1  dout carries data this cycle; no downstream backpressure.
REQ-009 dout_last  output  1  dout is the final word of the line; only high with dout_valid.

Function
REQ-010 Packing SHALL be RAW10: bytes 0..3 = pixel0..3[9:2]; byte 4 = {p3[1:0],p2[1:0],p1[1:0],p0[1:0]}.
REQ-011 Byte buffer SHALL hold 8 bytes max, FIFO order, with a 4-bit count (0..8).
REQ-012 Each cycle with count>=2: emit oldest two bytes on dout, count -= 2.
REQ-013 count==1 and last_pending set: emit the byte in dout[7:0], dout[15:8]=0x00, count -> 0.
REQ-014 count==1 and last_pending clear: no emission; dout_valid=0.
REQ-015 pix_ready SHALL be 1 iff count<=5 and last_pending clear; derived from registered state only.
REQ-016 Accepted group appends 5 bytes after the same cycle's emission; count never exceeds 8.
REQ-017 Accepting pix_last=1 sets last_pending; dout_last=1 on the word that empties the buffer, then last_pending clears.
REQ-018 dout, dout_valid, dout_last SHALL be registered; first word of a group accepted at edge t appears after edge t+1.
REQ-019 With pix_valid held high, dout_valid SHALL be continuous after the first word (sustained 2 bytes/cycle).
REQ-020 dout SHALL hold 0x0000 whenever dout_valid=0.
REQ-021 Odd total byte count per line: last word padded per REQ-013; even: no padding.

Reset
REQ-022 On reset low: count=0, last_pending=0, buffer=0, dout=0x0000, dout_valid=0, dout_last=0, pix_ready=0.
REQ-023 Reset mid-line SHALL discard buffered bytes; no partial word after release.
REQ-024 First cycle after release pix_ready=1 (count=0).

Structure
REQ-025 Package raw10_pkg: PIX_W=10, PIX_PER_GRP=4, BYTES_PER_GRP=5, BUF_BYTES=8.
REQ-026 Sub-module raw10_pack: combinational 64-bit group -> 40-bit five-byte vector per REQ-010; encoder holds buffer/control.

Verification
REQ-027 Single group 0x3FF,0x000,0x155,0x2AA, last=1 -> words 0x00FF, 0xAA55, 0x0093 (dout_last=1), then idle.
REQ-028 Two groups back-to-back, second last=1 -> exactly 5 words, no pad, dout_last on 5th only.
REQ-029 pix_valid held 8 groups (last on 8th) -> 20 words, dout_valid unbroken after first, count never >8.
REQ-030 Pixels 0xFFFF x4 -> identical output to 0x03FF x4 (upper bits ignored): 0xFFFF, 0xFFFF, 0x00FF last.
REQ-031 Reset low mid-line with count=6 -> outputs 0 immediately; after release, new group encodes cleanly from empty.
REQ-032 pix_valid toggling 1-of-3 cycles -> decoded stream matches reference model; gaps only show dout_valid=0.
